// File: rtl/invalidate_queue_pkg.sv
// Shared types and helpers for the invalidate queue: FSM states and the
// saturating hit counter.
package invalidate_queue_pkg;

    localparam int CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        INVQ_IDLE   = 2'd0,
        INVQ_LOOKUP = 2'd1,
        INVQ_CLEAR  = 2'd2
    } invq_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == CNT_MAX) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/invalidate_queue_inv_fifo.sv
// Circular FIFO of cache-line addresses; also exposes every slot and its
// valid bit so the owner can compare against all queued lines at once.
module inv_fifo
    import invalidate_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [DEPTH-1:0]       entry_valid,
    output logic [DEPTH*WIDTH-1:0] entries
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            entry_valid <= '0;
        end else begin
            if (do_push) begin
                wr_ptr              <= wr_ptr + 1'b1;
                entry_valid[wr_ptr] <= 1'b1;
            end
            if (do_pop) begin
                rd_ptr              <= rd_ptr + 1'b1;
                entry_valid[rd_ptr] <= 1'b0;
            end
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
        assign entries[i*WIDTH +: WIDTH] = mem[i];
    end

endmodule

// File: rtl/invalidate_queue.sv
// Per-cache invalidate queue: buffers coherence invalidates and drains them
// into the tag array around CPU traffic. Optional INVQ_MERGE_EN drops pushes
// whose line is already queued.
module invalidate_queue
    import invalidate_queue_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int OFFSET_W = 2,
    parameter int INDEX_W  = 6,
    parameter int DEPTH    = 4,
    localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               inv_valid,
    input  logic [ADDR_W-1:0]  inv_addr,
    output logic               inv_ready,
    input  logic               cpu_tag_busy,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               inv_pending,
    output logic               tag_rd_en,
    output logic [INDEX_W-1:0] tag_rd_index,
    input  logic [TAG_W-1:0]   tag_rd_tag,
    input  logic               tag_rd_valid,
    output logic               tag_clr_en,
    output logic [INDEX_W-1:0] tag_clr_index,
    output logic [CNT_W-1:0]   inv_hit_count
);

    localparam int LINE_W = ADDR_W - OFFSET_W;

    invq_state_t state, next_state;

    logic [LINE_W-1:0]       push_line;
    logic [LINE_W-1:0]       cpu_line;
    logic [LINE_W-1:0]       head_line;
    logic [INDEX_W-1:0]      head_index;
    logic [TAG_W-1:0]        head_tag;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    full;
    logic                    empty;
    logic [DEPTH-1:0]        entry_valid;
    logic [DEPTH*LINE_W-1:0] entries;
    logic                    pending_hit;
    logic                    merge_hit;
    logic                    lookup_hit;
    logic                    cnt_inc;
    logic                    unused_offset;

    // Offsets never take part in invalidation, so only the line is stored.
    assign push_line     = inv_addr[ADDR_W-1:OFFSET_W];
    assign cpu_line      = cpu_addr[ADDR_W-1:OFFSET_W];
    assign unused_offset = ^{inv_addr[OFFSET_W-1:0], cpu_addr[OFFSET_W-1:0]};
    assign head_index    = head_line[INDEX_W-1:0];
    assign head_tag      = head_line[LINE_W-1:INDEX_W];

    assign inv_ready     = !full;
    assign inv_pending   = pending_hit;
    assign tag_rd_index  = head_index;
    assign tag_clr_index = head_index;
    assign lookup_hit    = tag_rd_valid && (tag_rd_tag == head_tag);

    // The head stays in the FIFO until popped, so LOOKUP/CLEAR entries are covered.
    always_comb begin
        pending_hit = 1'b0;
        merge_hit   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_valid[i] && (entries[i*LINE_W +: LINE_W] == cpu_line))
                pending_hit = 1'b1;
            if (entry_valid[i] && (entries[i*LINE_W +: LINE_W] == push_line))
                merge_hit = 1'b1;
        end
    end

`ifdef INVQ_MERGE_EN
    assign fifo_push = inv_valid && inv_ready && !merge_hit;
`else
    assign fifo_push = inv_valid && inv_ready;
    logic unused_merge;
    assign unused_merge = merge_hit;
`endif

    inv_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (LINE_W)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .din         (push_line),
        .head        (head_line),
        .full        (full),
        .empty       (empty),
        .entry_valid (entry_valid),
        .entries     (entries)
    );

    always_ff @(posedge clock) begin
        if (reset)
            state <= INVQ_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        tag_rd_en  = 1'b0;
        tag_clr_en = 1'b0;
        fifo_pop   = 1'b0;
        cnt_inc    = 1'b0;
        case (state)
            INVQ_IDLE: begin
                if (!empty && !cpu_tag_busy) begin
                    tag_rd_en  = 1'b1;
                    next_state = INVQ_LOOKUP;
                end
            end
            INVQ_LOOKUP: begin
                if (lookup_hit) begin
                    next_state = INVQ_CLEAR;
                end else begin
                    fifo_pop   = 1'b1;
                    next_state = INVQ_IDLE;
                end
            end
            INVQ_CLEAR: begin
                // The CPU owns the port; the clear simply waits for a free cycle.
                if (!cpu_tag_busy) begin
                    tag_clr_en = 1'b1;
                    fifo_pop   = 1'b1;
                    cnt_inc    = 1'b1;
                    next_state = INVQ_IDLE;
                end
            end
            default: next_state = INVQ_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            inv_hit_count <= '0;
        else if (cnt_inc)
            inv_hit_count <= sat_inc(inv_hit_count);
    end

endmodule
